// File: rtl/ball_pkg.sv
// Shared types and default geometry for the ball engine.
// Direction encoding: 1 means "towards larger coordinate" on both axes,
// so RIGHT and DOWN are the positive directions.
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  localparam int DEF_COORD_W     = 10;
  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_BALL_R      = 4;
  localparam int DEF_PAD_L_X     = 16;
  localparam int DEF_PAD_R_X     = 623;
  localparam int DEF_PAD_HALF    = 24;
  localparam int DEF_SPEED_INIT  = 1;
  localparam int DEF_SPEED_MAX   = 4;
  localparam int DEF_HOLD_FRAMES = 60;

endpackage

// File: rtl/ball_axis.sv
// One motion axis: steps the position by +/-step, clamps at the lower or
// upper limit (lower only checked while moving negative, upper only while
// moving positive), reflects the direction and flags the limit contact.
// Pure combinational; the caller decides whether to commit the result.
module ball_axis
  import ball_pkg::*;
#(
  parameter int W = DEF_COORD_W
) (
  input  logic [W-1:0] pos,
  input  logic         dir,
  input  logic [2:0]   step,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic [W-1:0] pos_next,
  output logic         dir_next,
  output logic         limit
);

  logic signed [W:0] cand;
  logic signed [W:0] step_s;
  logic              lo_hit;
  logic              hi_hit;

  // Candidate position in W+1 signed bits so underflow/overflow is visible
  // to the limit compare instead of wrapping.
  always_comb begin
    step_s   = $signed({{(W-2){1'b0}}, step});
    cand     = dir ? ($signed({1'b0, pos}) + step_s)
                   : ($signed({1'b0, pos}) - step_s);
    lo_hit   = (dir == 1'b0) && (cand <= $signed({1'b0, lo}));
    hi_hit   = (dir == 1'b1) && (cand >= $signed({1'b0, hi}));
    limit    = lo_hit | hi_hit;
    pos_next = lo_hit ? lo : (hi_hit ? hi : cand[W-1:0]);
    dir_next = lo_hit ? 1'b1 : (hi_hit ? 1'b0 : dir);
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: serve from centre, per-frame motion, wall reflection,
// paddle hit/miss detection and a frozen hold period after a miss.
// Optional macro BALL_SPEEDUP_EN: each paddle hit raises the step size up
// to SPEED_MAX; it drops back to SPEED_INIT when a miss starts the hold.
module ball_engine
  import ball_pkg::*;
#(
  parameter int COORD_W     = DEF_COORD_W,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int BALL_R      = DEF_BALL_R,
  parameter int PAD_L_X     = DEF_PAD_L_X,
  parameter int PAD_R_X     = DEF_PAD_R_X,
  parameter int PAD_HALF    = DEF_PAD_HALF,
  parameter int SPEED_INIT  = DEF_SPEED_INIT,
  parameter int SPEED_MAX   = DEF_SPEED_MAX,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               serve,
  input  logic               serve_dir,
  input  logic [COORD_W-1:0] paddle_l_y,
  input  logic [COORD_W-1:0] paddle_r_y,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               in_play,
  output logic               hit,
  output logic               score_l,
  output logic               score_r,
  output logic [2:0]         speed
);

  localparam logic [COORD_W-1:0] CENTRE_X = COORD_W'(SCREEN_W / 2);
  localparam logic [COORD_W-1:0] CENTRE_Y = COORD_W'(SCREEN_H / 2);
  localparam logic [COORD_W-1:0] X_LO     = COORD_W'(PAD_L_X + BALL_R);
  localparam logic [COORD_W-1:0] X_HI     = COORD_W'(PAD_R_X - BALL_R);
  localparam logic [COORD_W-1:0] Y_LO     = COORD_W'(BALL_R);
  localparam logic [COORD_W-1:0] Y_HI     = COORD_W'(SCREEN_H - 1 - BALL_R);
  localparam int                 HOLD_W   = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_END = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [2:0]         SPD_INIT = 3'(SPEED_INIT);
`ifdef BALL_SPEEDUP_EN
  localparam logic [2:0]         SPD_MAX  = 3'(SPEED_MAX);
`endif

  state_t              state_reg;
  state_t              state_next;
  logic [COORD_W-1:0]  x_reg;
  logic [COORD_W-1:0]  y_reg;
  logic                dx_reg;
  logic                dy_reg;
  logic                vsel_reg;
  logic [2:0]          speed_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic                hit_reg;
  logic                score_l_reg;
  logic                score_r_reg;

  logic [COORD_W-1:0]  x_new;
  logic [COORD_W-1:0]  y_new;
  logic                x_dir_new;
  logic                y_dir_new;
  logic                x_limit;
  logic                y_limit;
  logic [COORD_W-1:0]  pad_y;
  logic signed [COORD_W:0] pad_diff;
  logic signed [COORD_W:0] pad_abs;
  logic                paddle_ok;
  logic                move_tick;
  logic                miss;

  ball_axis #(.W(COORD_W)) u_axis_x (
    .pos      (x_reg),
    .dir      (dx_reg),
    .step     (speed_reg),
    .lo       (X_LO),
    .hi       (X_HI),
    .pos_next (x_new),
    .dir_next (x_dir_new),
    .limit    (x_limit)
  );

  ball_axis #(.W(COORD_W)) u_axis_y (
    .pos      (y_reg),
    .dir      (dy_reg),
    .step     (speed_reg),
    .lo       (Y_LO),
    .hi       (Y_HI),
    .pos_next (y_new),
    .dir_next (y_dir_new),
    .limit    (y_limit)
  );

  // Paddle test against the already wall-clamped y of this tick; the paddle
  // is chosen by the side being approached.
  always_comb begin
    move_tick = (state_reg == MOVE) && frame_tick;
    pad_y     = (dx_reg == DIR_LEFT) ? paddle_l_y : paddle_r_y;
    pad_diff  = $signed({1'b0, y_new}) - $signed({1'b0, pad_y});
    pad_abs   = pad_diff[COORD_W] ? -pad_diff : pad_diff;
    paddle_ok = (pad_abs <= $signed((COORD_W + 1)'(PAD_HALF)));
    miss      = move_tick && x_limit && !paddle_ok;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic: serve only counts in IDLE, a miss starts the hold.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (serve) state_next = MOVE;
      MOVE:    if (miss) state_next = HOLD;
      HOLD:    if (frame_tick && (hold_cnt_reg == HOLD_END)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    in_play = (state_reg == MOVE);
  end

  // Ball datapath, direction latches, speed, hold counter and event pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_reg        <= CENTRE_X;
      y_reg        <= CENTRE_Y;
      dx_reg       <= DIR_RIGHT;
      dy_reg       <= DIR_UP;
      vsel_reg     <= DIR_UP;
      speed_reg    <= SPD_INIT;
      hold_cnt_reg <= '0;
      hit_reg      <= 1'b0;
      score_l_reg  <= 1'b0;
      score_r_reg  <= 1'b0;
    end else begin
      hit_reg     <= 1'b0;
      score_l_reg <= 1'b0;
      score_r_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          x_reg <= CENTRE_X;
          y_reg <= CENTRE_Y;
          if (serve) begin
            dx_reg   <= serve_dir;
            dy_reg   <= vsel_reg;
            vsel_reg <= ~vsel_reg;
          end
        end
        MOVE: begin
          if (move_tick) begin
            x_reg  <= x_new;
            y_reg  <= y_new;
            dy_reg <= y_limit ? y_dir_new : dy_reg;
            if (x_limit) begin
              if (paddle_ok) begin
                dx_reg  <= x_dir_new;
                hit_reg <= 1'b1;
`ifdef BALL_SPEEDUP_EN
                if (speed_reg < SPD_MAX) speed_reg <= speed_reg + 3'd1;
`endif
              end else begin
                score_l_reg  <= (dx_reg == DIR_RIGHT);
                score_r_reg  <= (dx_reg == DIR_LEFT);
                hold_cnt_reg <= '0;
`ifdef BALL_SPEEDUP_EN
                speed_reg    <= SPD_INIT;
`endif
              end
            end
          end
        end
        HOLD: begin
          if (frame_tick) begin
            if (hold_cnt_reg == HOLD_END) begin
              hold_cnt_reg <= '0;
              x_reg        <= CENTRE_X;
              y_reg        <= CENTRE_Y;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          x_reg <= CENTRE_X;
          y_reg <= CENTRE_Y;
        end
      endcase
    end
  end

  assign ball_x  = x_reg;
  assign ball_y  = y_reg;
  assign hit     = hit_reg;
  assign score_l = score_l_reg;
  assign score_r = score_r_reg;
  assign speed   = speed_reg;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine at default parameters. Expected speed after
// a hit follows whether BALL_SPEEDUP_EN is defined for this build.
module tb_ball_engine;

`ifdef BALL_SPEEDUP_EN
  localparam int SPD_HIT = 2;
`else
  localparam int SPD_HIT = 1;
`endif

  logic       clk;
  logic       reset_n;
  logic       frame_tick;
  logic       serve;
  logic       serve_dir;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       in_play;
  logic       hit;
  logic       score_l;
  logic       score_r;
  logic [2:0] speed;

  int checks = 0;
  int errors = 0;

  ball_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .serve      (serve),
    .serve_dir  (serve_dir),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .in_play    (in_play),
    .hit        (hit),
    .score_l    (score_l),
    .score_r    (score_r),
    .speed      (speed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers; all driving happens on the falling edge.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_serve(input logic dir);
    @(negedge clk);
    serve     = 1'b1;
    serve_dir = dir;
    @(negedge clk);
    serve     = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ball_x !== 10'd320 || ball_y !== 10'd240) begin
      errors++;
      $display("FAIL reset_pos: got (%0d,%0d) want (320,240)", ball_x, ball_y);
    end
    checks++;
    if (in_play !== 1'b0 || speed !== 3'd1) begin
      errors++;
      $display("FAIL reset_state: in_play=%0b speed=%0d want 0/1", in_play, speed);
    end
    checks++;
    if ({hit, score_l, score_r} !== 3'b000) begin
      errors++;
      $display("FAIL reset_pulses: hit/sl/sr=%b want 000", {hit, score_l, score_r});
    end
    $display("reset: ball=(%0d,%0d) in_play=%0b speed=%0d", ball_x, ball_y, in_play, speed);
  endtask

  task automatic test_serve();
    paddle_r_y = 10'd67;
    do_serve(1'b1);
    checks++;
    if (in_play !== 1'b1 || ball_x !== 10'd320 || ball_y !== 10'd240) begin
      errors++;
      $display("FAIL serve_enter: in_play=%0b ball=(%0d,%0d) want 1 (320,240)", in_play, ball_x, ball_y);
    end
    ticks(10);
    checks++;
    if (ball_x !== 10'd330 || ball_y !== 10'd230 || in_play !== 1'b1) begin
      errors++;
      $display("FAIL serve_10ticks: got (%0d,%0d) in_play=%0b want (330,230) 1", ball_x, ball_y, in_play);
    end
    $display("serve: 10 ticks ball=(%0d,%0d)", ball_x, ball_y);
  endtask

  task automatic test_wall();
    ticks(226);
    checks++;
    if (ball_x !== 10'd556 || ball_y !== 10'd4) begin
      errors++;
      $display("FAIL wall_tick236: got (%0d,%0d) want (556,4)", ball_x, ball_y);
    end
    ticks(1);
    checks++;
    if (ball_x !== 10'd557 || ball_y !== 10'd5) begin
      errors++;
      $display("FAIL wall_tick237: got (%0d,%0d) want (557,5)", ball_x, ball_y);
    end
    $display("wall: tick 237 ball=(%0d,%0d)", ball_x, ball_y);
  endtask

  task automatic test_hit();
    ticks(61);
    checks++;
    if (ball_x !== 10'd618 || ball_y !== 10'd66 || hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_tick298: got (%0d,%0d) hit=%0b want (618,66) 0", ball_x, ball_y, hit);
    end
    ticks(1);
    checks++;
    if (ball_x !== 10'd619 || ball_y !== 10'd67 || hit !== 1'b1 || score_l !== 1'b0) begin
      errors++;
      $display("FAIL hit_tick299: got (%0d,%0d) hit=%0b sl=%0b want (619,67) 1 0",
               ball_x, ball_y, hit, score_l);
    end
    checks++;
    if (speed !== 3'(SPD_HIT) || in_play !== 1'b1) begin
      errors++;
      $display("FAIL hit_speed: speed=%0d in_play=%0b want %0d 1", speed, in_play, SPD_HIT);
    end
    @(negedge clk);
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_pulse_len: hit=%0b want 0", hit);
    end
    ticks(1);
    checks++;
    if (ball_x !== 10'(619 - SPD_HIT) || ball_y !== 10'(67 + SPD_HIT)) begin
      errors++;
      $display("FAIL hit_reflect: got (%0d,%0d) want (%0d,%0d)", ball_x, ball_y, 619 - SPD_HIT, 67 + SPD_HIT);
    end
    $display("hit: after bounce ball=(%0d,%0d) speed=%0d", ball_x, ball_y, speed);
  endtask

  task automatic test_miss_right();
    do_reset();
    paddle_r_y = 10'd240;
    do_serve(1'b1);
    ticks(299);
    checks++;
    if (score_l !== 1'b1 || score_r !== 1'b0 || hit !== 1'b0) begin
      errors++;
      $display("FAIL miss_right_pulse: sl/sr/hit=%b want 100", {score_l, score_r, hit});
    end
    checks++;
    if (in_play !== 1'b0 || ball_x !== 10'd619 || ball_y !== 10'd67) begin
      errors++;
      $display("FAIL miss_right_state: in_play=%0b ball=(%0d,%0d) want 0 (619,67)", in_play, ball_x, ball_y);
    end
    $display("miss_right: ball=(%0d,%0d) score_l=%0b", ball_x, ball_y, score_l);
  endtask

  task automatic test_hold();
    do_serve(1'b0);
    checks++;
    if (in_play !== 1'b0) begin
      errors++;
      $display("FAIL hold_serve_ignored: in_play=%0b want 0", in_play);
    end
    ticks(59);
    checks++;
    if (ball_x !== 10'd619 || ball_y !== 10'd67 || in_play !== 1'b0) begin
      errors++;
      $display("FAIL hold_frozen: got (%0d,%0d) in_play=%0b want (619,67) 0", ball_x, ball_y, in_play);
    end
    ticks(1);
    checks++;
    if (ball_x !== 10'd320 || ball_y !== 10'd240 || speed !== 3'd1 || in_play !== 1'b0) begin
      errors++;
      $display("FAIL hold_exit: got (%0d,%0d) speed=%0d in_play=%0b want (320,240) 1 0",
               ball_x, ball_y, speed, in_play);
    end
    do_serve(1'b0);
    ticks(1);
    checks++;
    if (ball_x !== 10'd319 || ball_y !== 10'd241 || in_play !== 1'b1) begin
      errors++;
      $display("FAIL second_serve_down: got (%0d,%0d) in_play=%0b want (319,241) 1", ball_x, ball_y, in_play);
    end
    $display("hold: second serve ball=(%0d,%0d)", ball_x, ball_y);
  endtask

  task automatic test_miss_left();
    do_reset();
    paddle_l_y = 10'd0;
    do_serve(1'b0);
    ticks(300);
    checks++;
    if (ball_x !== 10'd20 || ball_y !== 10'd68 || score_r !== 1'b1 || score_l !== 1'b0 || in_play !== 1'b0) begin
      errors++;
      $display("FAIL miss_left: got (%0d,%0d) sr=%0b sl=%0b in_play=%0b want (20,68) 1 0 0",
               ball_x, ball_y, score_r, score_l, in_play);
    end
    $display("miss_left: ball=(%0d,%0d) score_r=%0b", ball_x, ball_y, score_r);
  endtask

  task automatic test_hit_left();
    do_reset();
    paddle_l_y = 10'd68;
    do_serve(1'b0);
    ticks(300);
    checks++;
    if (ball_x !== 10'd20 || hit !== 1'b1 || in_play !== 1'b1 || speed !== 3'(SPD_HIT)) begin
      errors++;
      $display("FAIL hit_left: x=%0d hit=%0b in_play=%0b speed=%0d want 20 1 1 %0d",
               ball_x, hit, in_play, speed, SPD_HIT);
    end
    ticks(1);
    checks++;
    if (ball_x !== 10'(20 + SPD_HIT)) begin
      errors++;
      $display("FAIL hit_left_reflect: x=%0d want %0d", ball_x, 20 + SPD_HIT);
    end
    $display("hit_left: ball=(%0d,%0d) speed=%0d", ball_x, ball_y, speed);
  endtask

  task automatic test_reset_mid_move();
    ticks(5);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (ball_x !== 10'd320 || ball_y !== 10'd240 || in_play !== 1'b0 || speed !== 3'd1) begin
      errors++;
      $display("FAIL reset_mid: got (%0d,%0d) in_play=%0b speed=%0d want (320,240) 0 1",
               ball_x, ball_y, in_play, speed);
    end
    do_serve(1'b1);
    ticks(1);
    checks++;
    if (ball_x !== 10'd321 || ball_y !== 10'd239) begin
      errors++;
      $display("FAIL reset_mid_serve: got (%0d,%0d) want (321,239)", ball_x, ball_y);
    end
    $display("reset_mid: serve after reset ball=(%0d,%0d)", ball_x, ball_y);
  endtask

  initial begin
    reset_n    = 1'b1;
    frame_tick = 1'b0;
    serve      = 1'b0;
    serve_dir  = 1'b0;
    paddle_l_y = 10'd240;
    paddle_r_y = 10'd240;
    test_reset();
    test_serve();
    test_wall();
    test_hit();
    test_miss_right();
    test_hold();
    test_miss_left();
    test_hit_left();
    test_reset_mid_move();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  COORD_W, 10, coordinate width
  SCREEN_W, 640, visible width (px)
  SCREEN_H, 480, visible height (px)
  BALL_R, 4, ball half-size (px)
  PAD_L_X, 16, left paddle face x
  PAD_R_X, 623, right paddle face x
  PAD_HALF, 24, paddle half-height
  SPEED_INIT, 1, step per frame after serve
  SPEED_MAX, 4, step ceiling
  HOLD_FRAMES, 60, frames frozen after a miss
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  clock
  reset_n  in  1  reset, synchronous, active-low
  frame_tick  in  1  one-cycle pulse per video frame
  serve  in  1  start-of-play request
  serve_dir  in  1  0 = serve left, 1 = serve right
  paddle_l_y  in  COORD_W  left paddle centre y
  paddle_r_y  in  COORD_W  right paddle centre y
  ball_x  out  COORD_W  ball centre x
  ball_y  out  COORD_W  ball centre y
  in_play  out  1  high in MOVE
  hit  out  1  one-cycle pulse on paddle bounce
  score_l  out  1  one-cycle pulse, right paddle missed
  score_r  out  1  one-cycle pulse, left paddle missed
  speed  out  3  current step size

Function
REQ-003 FSM SHALL have states IDLE, MOVE, HOLD.
REQ-004 IDLE SHALL hold the ball at (SCREEN_W/2, SCREEN_H/2) and go to MOVE on the cycle after serve=1.
REQ-005 On serve, dx SHALL take the value of serve_dir, and dy SHALL take vsel, a register that toggles on every serve (first serve after reset: up).
REQ-006 serve SHALL be ignored in MOVE and HOLD.
REQ-007 In MOVE, each frame_tick SHALL update ball_x/ball_y by ±speed on the next cycle; no motion without frame_tick.
REQ-008 Arithmetic SHALL use COORD_W+1 signed intermediates; no wrap-around.
REQ-009 Vertical: if y_next <= BALL_R, then y = BALL_R and dy becomes down; if y_next >= SCREEN_H-1-BALL_R, then y = SCREEN_H-1-BALL_R and dy becomes up.
REQ-010 Left plane: moving left with x_next <= PAD_L_X+BALL_R, x SHALL clamp to PAD_L_X+BALL_R.
  - If |ball_y_new - paddle_l_y| <= PAD_HALF: dx becomes right, hit pulses.
  - Otherwise: score_r pulses and the FSM goes to HOLD.
REQ-011 Right plane SHALL mirror REQ-010, using PAD_R_X-BALL_R, paddle_r_y and score_l.
REQ-012 Paddle tests SHALL use the same-tick clamped y; a wall and a plane event in one tick SHALL both apply.
REQ-013 HOLD SHALL freeze the position for HOLD_FRAMES frame_ticks, then recentre and enter IDLE.
REQ-014 hit, score_l and score_r SHALL be mutually exclusive and asserted in the same cycle as the position update.

Reset
REQ-015 reset_n=0 at a clk edge SHALL force, from any state, mid-move included:
  - state IDLE
  - ball_x=320, ball_y=240 (centre at defaults)
  - dx=right, dy=up, vsel=up
  - speed=SPEED_INIT
  - hold counter 0
  - hit, score_l, score_r, in_play all 0

Configuration
REQ-016 With macro BALL_SPEEDUP_EN defined:
  - each hit SHALL increment speed, saturating at SPEED_MAX
  - speed SHALL return to SPEED_INIT on entry to HOLD.
REQ-017 Without BALL_SPEEDUP_EN, speed SHALL be constant SPEED_INIT.

Structure
REQ-018 Package ball_pkg SHALL hold:
  - the state enum (IDLE/MOVE/HOLD)
  - direction constants DIR_LEFT/RIGHT/UP/DOWN
  - default geometry constants.
REQ-019 Sub-module ball_axis SHALL implement one axis (step, clamp, reflect, limit flag) and SHALL be instantiated twice.

Verification
REQ-020 The bench SHALL cover these directed scenarios (default parameters, macro defined):
  - Reset -> ball (320,240), IDLE, speed 1, all pulses 0.
  - serve, serve_dir=1, then 10 frame_ticks -> ball (330,230), in_play=1.
  - Continue to tick 236 -> y=4 and dy down; tick 237 -> (557,5).
  - Tick 299 with paddle_r_y=67 -> x=619, hit pulse, dx left, speed 2. Rerun with paddle_r_y=240 -> score_l pulse, HOLD.
  - In HOLD: serve ignored; after 60 ticks -> IDLE at (320,240), speed 1. Next serve goes down.
  - reset_n low mid-MOVE -> next cycle IDLE, centre, speed 1. With the macro undefined, speed stays 1 after a hit.
